// File: rtl/pll_rst_seq.sv
// PLL reset/lock supervisor: pulses PLL reset, waits for a filtered lock, then releases sys_rst.
// Optional macro PLL_RST_SEQ_RELOCK_EN: lock loss in RUN triggers a full re-acquisition.
module pll_rst_seq #(
    parameter int CNT_W        = 20,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 270000,
    parameter int LOCK_FILT    = 64,
    parameter int POST_DELAY   = 256,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] attempts,
    output logic       lock_lost
);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_FILTER,
        S_DELAY,
        S_RUN,
        S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(LOCK_FILT - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(POST_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic              lock_p0;
    logic              lock_s;
    state_t            state;
    logic [CNT_W-1:0]  cnt;

    // Stage p0/s: two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p0 <= lock;
            lock_s  <= lock_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RESET_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            attempts  <= 4'd1;
            lock_lost <= 1'b0;
        end else begin
            case (state)
                S_RESET_PLL: begin
                    if (cnt == HOLD_LAST) begin
                        state   <= S_WAIT_LOCK;
                        cnt     <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WAIT_LOCK: begin
                    // A lock seen in the timeout cycle takes priority over the retry
                    if (lock_s) begin
                        state <= S_FILTER;
                        cnt   <= CNT_ONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        pll_rst <= 1'b1;
                        if (attempts < RETRY_MAX) begin
                            state    <= S_RESET_PLL;
                            cnt      <= '0;
                            attempts <= sat_inc4(attempts);
                        end else begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_FILTER: begin
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt >= FILT_LAST) begin
                        state <= S_DELAY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DELAY: begin
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == DELAY_LAST) begin
                        state   <= S_RUN;
                        cnt     <= '0;
                        sys_rst <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        lock_lost <= 1'b1;
`ifdef PLL_RST_SEQ_RELOCK_EN
                        state    <= S_RESET_PLL;
                        cnt      <= '0;
                        pll_rst  <= 1'b1;
                        sys_rst  <= 1'b1;
                        ready    <= 1'b0;
                        attempts <= 4'd1;
`else
                        state <= S_RUN;
`endif
                    end
                end
                S_FAIL: begin
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                    fail    <= 1'b1;
                end
                default: begin
                    state   <= S_RESET_PLL;
                    cnt     <= '0;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                    ready   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Power-up and lock supervisor for the GW1NSR PLLVR primitive wrapper. It consumes the PLL `lock` output and drives the PLL `RESET` input.
- Runs on the raw 27 MHz crystal clock, which stays alive while the PLL is unlocked.
- Pulses PLL reset, waits for lock with a timeout and retry limit, filters lock glitches, then releases the system reset after a settle delay.
- `sys_rst` feeds the per-domain reset synchronizers of the Canny pipeline.

Parameters:
- CNT_W, 20, width of the shared cycle counter; every timing parameter below must be ≤ 2^CNT_W−1.
- RST_HOLD, 16, cycles `pll_rst` is held high per attempt (≥1).
- LOCK_TIMEOUT, 270000, cycles to wait for `lock` per attempt, 10 ms at 27 MHz (≥1).
- LOCK_FILT, 64, consecutive synchronized-high `lock` cycles required (≥1).
- POST_DELAY, 256, cycles between filtered lock and `sys_rst` release (≥1).
- MAX_RETRY, 3, PLL reset attempts before declaring failure (1..15).

Ports:
- clk  in  1  27 MHz reference clock (same net as the PLL `clkin`).
- rst  in  1  asynchronous active-high reset.
- lock  in  1  PLL lock; asynchronous to `clk`, double-flop synchronized inside to `lock_s`.
- pll_rst  out  1  to PLL `RESET`, active high.
- sys_rst  out  1  system reset, active high; registered, glitch-free.
- ready  out  1  high only in RUN.
- fail  out  1  high in FAIL (retries exhausted).
- attempts  out  4  number of PLL reset attempts started, saturating at 15.
- lock_lost  out  1  sticky: `lock_s` fell while in RUN; cleared only by `rst`.

Behaviour:
- Reset values:
  - state=RESET_PLL, counter=0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `attempts`=1, `lock_lost`=0, synchronizer flops=0.
- All outputs are registered and change on `clk` rising edges only.
- `lock_s` lags `lock` by 2 cycles.
- States and transitions:
  - RESET_PLL: `pll_rst`=1. The counter counts 0..RST_HOLD−1. At RST_HOLD−1: go to WAIT_LOCK, counter:=0. `pll_rst` is therefore high for exactly RST_HOLD cycles.
  - WAIT_LOCK: `pll_rst`=0 and the counter increments.
    - If `lock_s`=1: go to FILTER, counter:=1.
    - Else if counter=LOCK_TIMEOUT−1 and `attempts`<MAX_RETRY: go to RESET_PLL, `attempts`+1, counter:=0.
    - Else if counter=LOCK_TIMEOUT−1 and `attempts`=MAX_RETRY: go to FAIL.
    - If `lock_s`=1 arrives in the timeout cycle, lock wins.
  - FILTER: while `lock_s`=1 the counter increments.
    - On reaching LOCK_FILT: go to DELAY, counter:=0.
    - If `lock_s`=0 in any cycle: go to WAIT_LOCK, counter:=0. The timeout window restarts; `attempts` is unchanged.
  - DELAY: the counter counts 0..POST_DELAY−1.
    - At POST_DELAY−1 with `lock_s`=1: go to RUN.
    - If `lock_s`=0 in any cycle: go to WAIT_LOCK, counter:=0.
  - RUN: `sys_rst`=0, `ready`=1. If `lock_s` falls, `lock_lost`:=1 and the next state is set by the optional feature.
  - FAIL: terminal. `pll_rst`=1, `sys_rst`=1, `fail`=1. Exit only via `rst`.
- `sys_rst`=1 in every state except RUN. It deasserts on the edge entering RUN.
- Latency with stable lock: lock-rise to `sys_rst` fall = 2 (sync) + LOCK_FILT + POST_DELAY cycles.
- `rst` asserted mid-operation: immediate asynchronous return to the reset values, including `pll_rst`=1 and `sys_rst`=1 in the same instant.
- `attempts` saturates at 15 and never wraps.
- The counter never exceeds its terminal value, so no wrap is possible.

Optional Feature:
- Macro: PLL_RST_SEQ_RELOCK_EN.
- Defined: on `lock_s` falling in RUN, go to RESET_PLL, `sys_rst`:=1 next cycle, `attempts`:=1, counter:=0. This is a full re-acquisition with a fresh retry budget.
- Undefined: RUN is held. `sys_rst` stays 0 and `ready` stays 1; only `lock_lost` is set. The system tolerates lock loss and must not be reset.

Test Plan:
All scenarios use RST_HOLD=4, LOCK_TIMEOUT=20, LOCK_FILT=5, POST_DELAY=8, MAX_RETRY=3.
- Nominal:
  - Stimulus: release `rst`; raise `lock` 6 cycles after `pll_rst` falls.
  - Required response: `pll_rst` high exactly 4 cycles; `sys_rst` falls 2+5+8=15 cycles after `lock` rises; `ready`=1; `attempts`=1.
- Timeout/retry/fail:
  - Stimulus: `lock` held 0.
  - Required response: three 4-cycle `pll_rst` pulses separated by 20-cycle waits; `attempts` 1→2→3; then `fail`=1, `pll_rst`=1, `sys_rst`=1 permanently.
- Glitch filter:
  - Stimulus: `lock` high 3 cycles, low 1, then high stable.
  - Required response: FILTER aborts to WAIT_LOCK; `sys_rst` falls 15 cycles after the second rise; `attempts` stays 1.
- Lock loss in RUN:
  - Stimulus: drop `lock` for 1 cycle.
  - Required response, with macro: `lock_lost`=1, `sys_rst`=1, new 4-cycle `pll_rst` pulse, `attempts`=1.
  - Required response, without macro: `lock_lost`=1, `sys_rst`=0, `ready`=1, `pll_rst`=0.
- Async reset mid-sequence:
  - Stimulus: assert `rst` during DELAY between clock edges.
  - Required response: `pll_rst`=1 and `sys_rst`=1 before the next edge; all other outputs at reset values; the sequence restarts cleanly on release.
- Lock at timeout boundary:
  - Stimulus: `lock_s` rises in the cycle where counter=19.
  - Required response: enters FILTER, no retry; `attempts` stays 1.
